// File: rtl/xfer_pkg.sv
// Shared types and widths for the DMA fetch-path transfer request generator.
// Holds the request FSM state encoding used by transfer_request_generator.
package xfer_pkg;

   localparam int ADDR_W      = 64;
   localparam int LEN_W       = 36;
   localparam int REQ_BYTES_W = 13;
   localparam int PAGE_BYTES  = 4096;
   localparam int PAGE_OFS_W  = 12;
   localparam int OUTST_W     = 8;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_CALC,
      ST_ISSUE,
      ST_UPDATE,
      ST_WAIT_DROP,
      ST_WAIT_RISE
   } xfer_req_state_t;

endpackage

// File: rtl/transfer_request_generator_size.sv
// burst_size_calc: min(remaining length, max burst, page boundary limit).
// Define BOUNDARY_4K_SPLIT_EN to keep bursts inside one 4 KiB page.
module burst_size_calc
   import xfer_pkg::*;
#(
   parameter int MAX_BURST_BYTES = 512
) (
   input  logic [ADDR_W-1:0]      address,
   input  logic [LEN_W-1:0]       length,
   output logic [REQ_BYTES_W-1:0] bytes
);

   localparam logic [LEN_W-1:0] MAX_BURST = LEN_W'(MAX_BURST_BYTES);

   logic [LEN_W-1:0] boundary;
   logic [LEN_W-1:0] len_cap;
   logic [LEN_W-1:0] burst;
   logic             unused_bits;

   always_comb begin
`ifdef BOUNDARY_4K_SPLIT_EN
      boundary = LEN_W'(PAGE_BYTES) - LEN_W'(address[PAGE_OFS_W-1:0]);
`else
      boundary = LEN_W'(PAGE_BYTES);
`endif
      len_cap = (length < MAX_BURST) ? length : MAX_BURST;
      burst   = (len_cap < boundary) ? len_cap : boundary;
   end

   // All three limits are <= 4096, so the 13-bit truncation is lossless.
   assign bytes = burst[REQ_BYTES_W-1:0];

   assign unused_bits = ^{address, burst[LEN_W-1:REQ_BYTES_W]};

endmodule

// File: rtl/transfer_request_generator.sv
// Turns incrementer transfer parameters into credit-limited read bursts.
// Page splitting is selected by BOUNDARY_4K_SPLIT_EN (see burst_size_calc).
module transfer_request_generator
   import xfer_pkg::*;
#(
   parameter int MAX_BURST_BYTES = 512,
   parameter int MAX_OUTSTANDING = 8
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   enable,
   input  logic [ADDR_W-1:0]      param_address,
   input  logic [LEN_W-1:0]       param_length,
   input  logic                   param_valid,
   input  logic                   param_complete,
   output logic                   param_update,
   output logic [LEN_W-1:0]       param_size,
   output logic                   req_valid,
   input  logic                   req_ready,
   output logic [ADDR_W-1:0]      req_address,
   output logic [REQ_BYTES_W-1:0] req_bytes,
   input  logic                   rsp_done,
   output logic [OUTST_W-1:0]     outstanding,
   output logic                   busy
);

   xfer_req_state_t state;
   xfer_req_state_t state_nxt;

   logic [REQ_BYTES_W-1:0] calc_bytes;
   logic                   hs;
   logic                   done_ok;
   logic                   credit;
   logic                   start;

   burst_size_calc #(
      .MAX_BURST_BYTES(MAX_BURST_BYTES)
   ) u_size (
      .address(param_address),
      .length (param_length),
      .bytes  (calc_bytes)
   );

   assign hs      = (state == ST_ISSUE) && req_ready;
   assign done_ok = rsp_done && (outstanding != '0);
   // A completion in the same cycle frees a slot early.
   assign credit  = (outstanding < OUTST_W'(MAX_OUTSTANDING)) || rsp_done;
   assign start   = enable && param_valid && !param_complete &&
                    (param_length != '0) && credit;

   always_comb begin
      state_nxt = state;
      unique case (state)
         ST_IDLE:      if (start) state_nxt = ST_CALC;
         ST_CALC:      state_nxt = ST_ISSUE;
         ST_ISSUE:     if (req_ready) state_nxt = ST_UPDATE;
         ST_UPDATE:    state_nxt = ST_WAIT_DROP;
         ST_WAIT_DROP: if (!param_valid) state_nxt = ST_WAIT_RISE;
         ST_WAIT_RISE: if (param_valid) state_nxt = ST_IDLE;
         default:      state_nxt = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state       <= ST_IDLE;
         req_address <= '0;
         req_bytes   <= '0;
         outstanding <= '0;
      end else begin
         state <= state_nxt;
         if (state == ST_CALC) begin
            req_address <= param_address;
            req_bytes   <= calc_bytes;
         end
         if (hs && !done_ok)
            outstanding <= outstanding + 1'b1;
         else if (!hs && done_ok)
            outstanding <= outstanding - 1'b1;
      end
   end

   assign req_valid    = (state == ST_ISSUE);
   assign param_update = (state == ST_UPDATE);
   assign param_size   = (state == ST_UPDATE) ? LEN_W'(req_bytes) : '0;
   assign busy         = (state != ST_IDLE) || (outstanding != '0);

endmodule

// File: tb/tb_transfer_request_generator.sv
// Self-checking bench for transfer_request_generator: vector table,
// hand-written corner sequences and randomized transfers vs a burst model.
module tb_transfer_request_generator;
   import xfer_pkg::*;

   localparam int MAXB = 512;
   localparam int MAXO = 2;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        enable = 1'b0;
   logic [63:0] param_address = '0;
   logic [35:0] param_length = '0;
   logic        param_valid = 1'b0;
   logic        param_complete = 1'b0;
   logic        param_update;
   logic [35:0] param_size;
   logic        req_valid;
   logic        req_ready = 1'b1;
   logic [63:0] req_address;
   logic [12:0] req_bytes;
   logic        rsp_done = 1'b0;
   logic [7:0]  outstanding;
   logic        busy;

   transfer_request_generator #(
      .MAX_BURST_BYTES(MAXB),
      .MAX_OUTSTANDING(MAXO)
   ) dut (
      .clk           (clk),
      .rst           (rst),
      .enable        (enable),
      .param_address (param_address),
      .param_length  (param_length),
      .param_valid   (param_valid),
      .param_complete(param_complete),
      .param_update  (param_update),
      .param_size    (param_size),
      .req_valid     (req_valid),
      .req_ready     (req_ready),
      .req_address   (req_address),
      .req_bytes     (req_bytes),
      .rsp_done      (rsp_done),
      .outstanding   (outstanding),
      .busy          (busy)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [63:0] addr;
      logic [12:0] bytes;
   } burst_t;

   typedef struct {
      logic [63:0] addr;
      logic [35:0] len;
      int          n;
      logic [12:0] b0;
      logic [12:0] b1;
      logic [12:0] b2;
   } vec_t;

   int          cmp_n = 0;
   int          err_n = 0;
   burst_t      exp_q[$];
   burst_t      got_q[$];
   int          got_n = 0;
   int          upd_n = 0;
   int          m_out = 0;
   int          rise_t = 0;
   bit          hs_last = 0;
   bit          upd_pending = 0;
   bit          rsp_auto = 0;
   bit          rdy_rand = 0;
   bit          s_valid = 0;
   bit          busy_seen = 0;
   logic [12:0] last_bytes = '0;
   logic [35:0] upd_size = '0;

   task automatic chk(input string nm, input logic [63:0] act,
                      input logic [63:0] exp);
      cmp_n++;
      if (act !== exp) begin
         err_n++;
         $display("FAIL %s: got %0h want %0h", nm, act, exp);
      end
   endtask

   task automatic tmo(input string nm, input int got, input int want);
      cmp_n++;
      err_n++;
      $display("FAIL timeout_%s: got %0d want %0d", nm, got, want);
   endtask

   // One clock: check at negedge, then drive the environment after posedge.
   task automatic step();
      bit hs;
      @(negedge clk);
      s_valid = req_valid;
      if (busy) busy_seen = 1;
      if (rst) begin
         m_out   = 0;
         hs_last = 0;
      end else begin
         chk("outstanding", 64'(outstanding), 64'(m_out));
         if (m_out != 0) chk("busy_inflight", 64'(busy), 64'd1);
         if (param_update || hs_last)
            chk("update_latency", 64'(param_update), 64'(hs_last));
         if (param_update) begin
            chk("param_size", 64'(param_size), 64'(last_bytes));
            chk("update_excl_valid", 64'(req_valid), 64'd0);
            upd_n++;
            upd_pending = 1;
            upd_size = param_size;
         end
         if (req_valid) begin
            if (got_n < exp_q.size()) begin
               chk("req_address", req_address, exp_q[got_n].addr);
               chk("req_bytes", 64'(req_bytes), 64'(exp_q[got_n].bytes));
            end else begin
               cmp_n++;
               err_n++;
               $display("FAIL unexpected_req: got %0h/%0d want none",
                        req_address, req_bytes);
            end
         end
         hs = req_valid && req_ready;
         if (hs) begin
            got_q.push_back('{req_address, req_bytes});
            if (got_n < exp_q.size()) last_bytes = exp_q[got_n].bytes;
            got_n++;
         end
         m_out = m_out + int'(hs) - int'(rsp_done && m_out > 0);
         hs_last = hs;
      end
      @(posedge clk);
      #1;
      // Incrementer: drop valid, advance, restore 4 cycles later.
      if (upd_pending) begin
         upd_pending    = 0;
         param_valid    = 0;
         param_address  = param_address + 64'(upd_size);
         param_length   = param_length - upd_size;
         param_complete = (param_length == '0);
         rise_t         = 4;
      end else if (rise_t > 0) begin
         rise_t--;
         if (rise_t == 0) param_valid = 1;
      end
      rsp_done = 1'b0;
      if (rsp_auto)
         rsp_done = (m_out > 0) ? ($urandom_range(0, 2) == 0)
                                : ($urandom_range(0, 15) == 0);
      if (rdy_rand) req_ready = ($urandom_range(0, 3) != 0);
   endtask

   // Reference model: split a transfer into bursts by plain arithmetic.
   task automatic load(input logic [63:0] a, input logic [35:0] l,
                       input logic cmpl);
      longint unsigned aa, ll, b, room;
      exp_q.delete();
      got_q.delete();
      got_n = 0;
      upd_n = 0;
      param_address  = a;
      param_length   = l;
      param_complete = cmpl;
      param_valid    = 1;
      aa = a;
      ll = cmpl ? 0 : 64'(l);
      while (ll != 0) begin
         b = (ll < MAXB) ? ll : MAXB;
         room = 4096 - (aa % 4096);
`ifdef BOUNDARY_4K_SPLIT_EN
         if (b > room) b = room;
`endif
         if (room == 0) b = 0;
         exp_q.push_back('{aa, b[12:0]});
         aa = aa + b;
         ll = ll - b;
      end
   endtask

   task automatic wait_done(input string nm, input int budget);
      int c;
      c = 0;
      while (!(got_n == exp_q.size() && upd_n == got_n && param_valid &&
               rise_t == 0 && !upd_pending) && c < budget) begin
         step();
         c++;
      end
      if (c >= budget) tmo(nm, got_n, exp_q.size());
      repeat (12) step();
   endtask

   task automatic drain(input int budget);
      int c;
      c = 0;
      rsp_auto = 1;
      while (m_out != 0 && c < budget) begin
         step();
         c++;
      end
      if (c >= budget) tmo("drain", m_out, 0);
      rsp_auto = 0;
      repeat (3) step();
      chk("busy_idle", 64'(busy), 64'd0);
   endtask

   task automatic wait_valid(input string nm, input int budget);
      int c;
      c = 0;
      while (!s_valid && c < budget) begin
         step();
         c++;
      end
      if (c >= budget) tmo(nm, 0, 1);
   endtask

   task automatic chk_reset(input string nm);
      chk({nm, "_req_valid"}, 64'(req_valid), 64'd0);
      chk({nm, "_req_address"}, req_address, 64'd0);
      chk({nm, "_req_bytes"}, 64'(req_bytes), 64'd0);
      chk({nm, "_param_update"}, 64'(param_update), 64'd0);
      chk({nm, "_param_size"}, 64'(param_size), 64'd0);
      chk({nm, "_outstanding"}, 64'(outstanding), 64'd0);
      chk({nm, "_busy"}, 64'(busy), 64'd0);
   endtask

   initial begin
      vec_t        tbl[4];
      logic [63:0] a;
      logic [12:0] b;
      logic [63:0] ra;
      logic [35:0] rl;

`ifdef BOUNDARY_4K_SPLIT_EN
      tbl[0] = '{64'h1000, 36'd1024, 2, 13'd512, 13'd512, 13'd0};
      tbl[1] = '{64'h0F80, 36'd1000, 3, 13'd128, 13'd512, 13'd360};
      tbl[2] = '{64'h0FFF, 36'd3, 2, 13'd1, 13'd2, 13'd0};
      tbl[3] = '{64'hA000_0000_0000_0F00, 36'd700, 2, 13'd256, 13'd444,
                 13'd0};
`else
      tbl[0] = '{64'h1000, 36'd1024, 2, 13'd512, 13'd512, 13'd0};
      tbl[1] = '{64'h0F80, 36'd1000, 2, 13'd512, 13'd488, 13'd0};
      tbl[2] = '{64'h0FFF, 36'd3, 1, 13'd3, 13'd0, 13'd0};
      tbl[3] = '{64'hA000_0000_0000_0F00, 36'd700, 2, 13'd512, 13'd188,
                 13'd0};
`endif

      repeat (3) @(posedge clk);
      @(negedge clk);
      chk_reset("reset");
      @(posedge clk);
      #1;
      rst    = 0;
      enable = 1;

      for (int i = 0; i < 4; i++) begin
         rsp_auto = (i != 0);
         load(tbl[i].addr, tbl[i].len, 1'b0);
         wait_done($sformatf("tbl%0d", i), 400);
         chk($sformatf("tbl%0d_count", i), 64'(got_q.size()),
             64'(tbl[i].n));
         a = tbl[i].addr;
         for (int k = 0; k < got_q.size() && k < 3; k++) begin
            b = (k == 0) ? tbl[i].b0 : (k == 1) ? tbl[i].b1 : tbl[i].b2;
            chk($sformatf("tbl%0d_addr%0d", i, k), got_q[k].addr, a);
            chk($sformatf("tbl%0d_bytes%0d", i, k), 64'(got_q[k].bytes),
                64'(b));
            a = a + 64'(b);
         end
         if (i == 0) begin
            chk("hold_outstanding", 64'(outstanding), 64'd2);
            chk("hold_busy", 64'(busy), 64'd1);
            rsp_done = 1;
            step();
            rsp_done = 1;
            step();
            step();
            chk("released_outstanding", 64'(outstanding), 64'd0);
            chk("released_busy", 64'(busy), 64'd0);
         end
         drain(400);
      end

      // Credit limit, ready stall, and done coinciding with a handshake.
      rsp_auto  = 0;
      req_ready = 1;
      load(64'h8000, 36'd2048, 1'b0);
      for (int c = 0; c < 200 && got_n < 2; c++) step();
      repeat (20) step();
      chk("credit_block_bursts", 64'(got_n), 64'd2);
      chk("credit_block_out", 64'(outstanding), 64'd2);
      req_ready = 0;
      rsp_done  = 1;
      step();
      wait_valid("credit_release", 20);
      repeat (5) step();
      chk("stall_no_update", 64'(upd_n), 64'd2);
      req_ready = 1;
      rsp_done  = 1;
      step();
      step();
      chk("coincide_out", 64'(outstanding), 64'd1);
      chk("coincide_bursts", 64'(got_n), 64'd3);
      rsp_auto = 1;
      wait_done("credit", 400);
      drain(400);

      // enable dropped mid-burst: the burst finishes, then the block holds.
      load(64'h3000, 36'd1024, 1'b0);
      req_ready = 0;
      wait_valid("enable_issue", 20);
      enable    = 0;
      req_ready = 1;
      repeat (20) step();
      chk("enable_hold_bursts", 64'(got_n), 64'd1);
      chk("enable_hold_updates", 64'(upd_n), 64'd1);
      enable = 1;
      wait_done("enable", 400);
      drain(400);

      // Reset while a request is pending.
      load(64'h9000, 36'd256, 1'b0);
      req_ready = 0;
      wait_valid("reset_issue", 20);
      rst = 1;
      step();
      @(negedge clk);
      chk_reset("midreset");
      @(posedge clk);
      #1;
      enable      = 0;
      param_valid = 0;
      rise_t      = 0;
      upd_pending = 0;
      rst         = 0;
      req_ready   = 1;
      repeat (3) step();
      enable = 1;

      // Nothing to do: zero length, or already complete.
      busy_seen = 0;
      load(64'h5000, 36'd0, 1'b0);
      wait_done("len0", 50);
      chk("len0_bursts", 64'(got_q.size()), 64'd0);
      chk("len0_busy", 64'(busy_seen), 64'd0);
      busy_seen = 0;
      load(64'h5000, 36'd100, 1'b1);
      wait_done("complete", 50);
      chk("complete_bursts", 64'(got_q.size()), 64'd0);
      chk("complete_busy", 64'(busy_seen), 64'd0);

      // Randomized transfers against the burst model.
      rdy_rand = 1;
      for (int t = 0; t < 25; t++) begin
         ra = {$urandom, $urandom};
         if ($urandom_range(0, 1) == 1)
            ra[11:0] = 12'(4096 - $urandom_range(1, 600));
         rl = 36'($urandom_range(1, 2500));
         rsp_auto = 1;
         load(ra, rl, 1'b0);
         wait_done($sformatf("rand%0d", t), 1500);
         chk($sformatf("rand%0d_count", t), 64'(got_q.size()),
             64'(exp_q.size()));
         drain(400);
      end
      rdy_rand  = 0;
      req_ready = 1;

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_n, err_n);
      $finish;
   end

endmodule

// File: doc/transfer_request_generator.md
# transfer_request_generator

Consumes the running transfer parameters (address, remaining length, valid, complete) published by the address incrementer of the matcher's DMA fetch path and turns them into individual read-burst requests on a valid/ready request channel. Each accepted burst is reported back to the incrementer as a one-cycle update pulse carrying the burst size, so the incrementer advances address and length. Bursts are limited by a maximum burst size and the remaining length, and can optionally be kept from crossing 4 KiB boundaries. A credit counter bounds the number of bursts in flight.

## Interface
- MAX_BURST_BYTES, 512: upper bound on one burst; legal range 1..4096.
- MAX_OUTSTANDING, 8: maximum bursts issued but not yet completed; legal range 1..255.
- clk  in  1  clock.
- rst  in  1  reset, synchronous, active-high.
- enable  in  1  permits new bursts to start; an in-progress burst always finishes.
- param_address  in  64  current transfer address.
- param_length  in  36  remaining bytes.
- param_valid  in  1  parameters are stable and may be used.
- param_complete  in  1  no data remains.
- param_update  out  1  one-cycle pulse that advances the incrementer.
- param_size  out  36  bytes consumed by the burst; held stable while param_update = 1.
- req_valid  out  1  burst request valid.
- req_ready  in  1  downstream accepts the request.
- req_address  out  64  burst start address.
- req_bytes  out  13  burst length in bytes, 1..4096.
- rsp_done  in  1  one-cycle pulse per completed burst.
- outstanding  out  8  bursts currently in flight.
- busy  out  1  high in any state other than IDLE, or while outstanding != 0.

## Operation
- States: IDLE, CALC, ISSUE, UPDATE, WAIT_DROP, WAIT_RISE.
- IDLE to CALC requires all of the following: enable = 1, param_valid = 1, param_complete = 0, param_length != 0, and credit available.
  - Credit is available when outstanding < MAX_OUTSTANDING, or when rsp_done = 1 in the same cycle.
  - If param_length = 0, the block stays in IDLE and treats the transfer as complete.
- CALC:
  - Register req_address = param_address.
  - Register req_bytes = min(param_length, MAX_BURST_BYTES, boundary limit). The boundary limit is defined under Configuration.
  - Compare at full 36-bit width, then truncate to 13 bits.
  - Next state is ISSUE.
- ISSUE:
  - req_valid = 1.
  - req_address and req_bytes stay stable until req_valid && req_ready.
  - On that handshake: outstanding increments and the state moves to UPDATE.
- UPDATE:
  - param_update = 1 for exactly this cycle.
  - param_size = zero-extended req_bytes.
  - Next state is WAIT_DROP.
- WAIT_DROP: wait for param_valid = 0, then go to WAIT_RISE.
- WAIT_RISE: wait for param_valid = 1, then go to IDLE. The updated parameters are sampled only after this point.
- outstanding counter:
  - +1 on a request handshake, -1 on rsp_done. Both in the same cycle leaves it unchanged.
  - rsp_done while outstanding = 0 is ignored; the counter saturates at 0.
- enable deasserted mid-burst: the current state sequence completes; the block then holds in IDLE.

## Timing
- Reset values: req_valid 0, req_address 0, req_bytes 0, param_update 0, param_size 0, outstanding 0, busy 0, state IDLE.
- Reset mid-operation: everything above is cleared at the next edge, including a pending req_valid. Downstream shares rst.
- Latency:
  - req_valid rises 2 cycles after the IDLE cycle that qualifies.
  - param_update rises 1 cycle after the request handshake.
- The incrementer drops param_valid 1 cycle after sampling param_update and restores it 4 cycles later.
  - Minimum burst-to-burst interval is therefore about 9 cycles with req_ready held high.
- param_update is never asserted while req_valid = 1.

## Configuration
- BOUNDARY_4K_SPLIT_EN defined:
  - Boundary limit = 4096 - param_address[11:0], which is 1..4096.
  - No burst crosses a 4 KiB address boundary.
- BOUNDARY_4K_SPLIT_EN undefined:
  - Boundary limit = 4096 (no split).
  - Bursts are limited only by MAX_BURST_BYTES and the remaining length.

## Structure
- Shared package xfer_pkg holds:
  - state enum xfer_req_state_t;
  - ADDR_W = 64, LEN_W = 36, REQ_BYTES_W = 13, PAGE_BYTES = 4096.
- One sub-module, burst_size_calc: a combinational three-way minimum with boundary computation. It contains the BOUNDARY_4K_SPLIT_EN conditional.
- The remaining logic stays in transfer_request_generator: FSM, request registers, and credit counter.

## Test plan
- Build with BOUNDARY_4K_SPLIT_EN; address 0x1000, length 1024, MAX_BURST 512, req_ready = 1.
  - Expect 2 requests: (0x1000, 512) and (0x1200, 512), each followed by param_update with size 512.
  - Then complete = 1, no further requests, and outstanding = 2 until two rsp_done pulses.
- Build with BOUNDARY_4K_SPLIT_EN; address 0x0F80, length 1000.
  - Expect first request (0x0F80, 128), then (0x1000, 512), then (0x1200, 360).
  - Without the macro, expect (0x0F80, 512), (0x1180, 488).
- req_ready held low for 5 cycles in ISSUE: req_address and req_bytes stay constant, and no param_update occurs until the handshake.
- MAX_OUTSTANDING = 2 with no rsp_done: after 2 requests the FSM holds in IDLE.
  - One rsp_done pulse lets the third request start.
  - rsp_done coinciding with a handshake leaves outstanding unchanged.
- Assert rst while in ISSUE with req_valid = 1: the next cycle shows all outputs at reset values and state IDLE.
- param_length = 0 with complete = 0, or param_complete = 1: no request is ever issued and busy stays 0.
